// File: rtl/palette_lut_pkg.sv
// Shared definitions for the palette lookup block: default sizes, FSM
// encoding and the built-in default palette loaded after reset.
package palette_lut_pkg;

    localparam int          IDX_W_DEF     = 4;
    localparam int          RGB_W_DEF     = 12;
    localparam int          NUM_BANKS_DEF = 2;
    localparam int          TRANS_IDX_DEF = 0;
    localparam logic [11:0] ERR_COLOR_DEF = 12'hF0F;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A single bank still needs a one-bit select so the ports never vanish.
    function automatic int bank_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    // Built-in palette; anything past entry 8 shows up as the debug colour.
    function automatic logic [11:0] default_color(input int unsigned idx,
                                                  input logic [11:0] err_color);
        case (idx)
            0:       return 12'h000;
            1:       return 12'hD42;
            2:       return 12'h921;
            3:       return 12'hFF9;
            4:       return 12'h210;
            5:       return 12'h778;
            6:       return 12'h6B4;
            7:       return 12'hDD0;
            8:       return 12'hFFF;
            default: return err_color;
        endcase
    endfunction

endpackage

// File: rtl/palette_lut_if.sv
// Pixel lookup, bank select and palette write signals of the palette block.
// The master side is the pixel pipeline / CPU, the slave side is palette_lut.
interface palette_lut_if
    import palette_lut_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int RGB_W  = RGB_W_DEF,
    parameter int BANK_W = bank_width(NUM_BANKS_DEF)
) ();

    logic              pix_valid_in;
    logic [IDX_W-1:0]  pix_index;
    logic              pix_valid_out;
    logic [RGB_W-1:0]  pix_rgb;
    logic              pix_opaque;
    logic              frame_start;
    logic [BANK_W-1:0] bank_sel_req;
    logic [BANK_W-1:0] active_bank;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_addr;
    logic [RGB_W-1:0]  wr_data;
    logic              wr_ready;
    logic              init_done;

    modport master (
        output pix_valid_in, pix_index, frame_start, bank_sel_req,
               wr_en, wr_bank, wr_addr, wr_data,
        input  pix_valid_out, pix_rgb, pix_opaque, active_bank,
               wr_ready, init_done
    );

    modport slave (
        input  pix_valid_in, pix_index, frame_start, bank_sel_req,
               wr_en, wr_bank, wr_addr, wr_data,
        output pix_valid_out, pix_rgb, pix_opaque, active_bank,
               wr_ready, init_done
    );

endinterface

// File: rtl/palette_lut_bank_ram.sv
// Flat register file holding every palette bank, addressed as {bank, index}.
// One synchronous write port and one read port whose data is registered, so a
// read and a write of the same entry at one edge returns the old colour.
module palette_lut_bank_ram
    import palette_lut_pkg::*;
#(
    parameter int AW    = 5,
    parameter int RGB_W = RGB_W_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [RGB_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [RGB_W-1:0] rdata
);

    logic [RGB_W-1:0] mem_q [2**AW];
    logic [RGB_W-1:0] rdata_q;
    logic [RGB_W-1:0] rdata_d;

    // Read data only moves on a real lookup so the output colour can hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Palette storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read data (no reset; the top masks it until a lookup lands).
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/palette_lut.sv
// Multi-bank colour palette: loads the default palette into every bank after
// reset, then serves index->RGB lookups with a fixed two-cycle latency, accepts
// runtime palette writes and switches the displayed bank on frame boundaries.
module palette_lut
    import palette_lut_pkg::*;
#(
    parameter int               IDX_W     = IDX_W_DEF,
    parameter int               RGB_W     = RGB_W_DEF,
    parameter int               NUM_BANKS = NUM_BANKS_DEF,
    parameter int               TRANS_IDX = TRANS_IDX_DEF,
    parameter logic [RGB_W-1:0] ERR_COLOR = RGB_W'(ERR_COLOR_DEF)
) (
    input logic          clk,
    input logic          rst,
    palette_lut_if.slave bus
);

    localparam int                BANK_W      = bank_width(NUM_BANKS);
    localparam int                DEPTH       = 2 ** IDX_W;
    localparam int                TOTAL       = NUM_BANKS * DEPTH;
    localparam int                AW          = BANK_W + IDX_W;
    localparam int                CNT_W       = AW + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0]  TRANS_I     = IDX_W'(TRANS_IDX);
    localparam logic [BANK_W:0]   NUM_BANKS_W = (BANK_W + 1)'(NUM_BANKS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [BANK_W-1:0] active_bank_q, active_bank_d;
    logic              s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]  s1_index_q, s1_index_d;
    logic [BANK_W-1:0] s1_bank_q, s1_bank_d;
    logic              out_valid_q, out_valid_d;
    logic              out_opaque_q, out_opaque_d;

    logic              run;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [RGB_W-1:0]  ram_wdata;
    logic              ram_re;
    logic [AW-1:0]     ram_raddr;
    logic [RGB_W-1:0]  ram_rdata;

    // Bank numbers at or above NUM_BANKS do not exist and are ignored.
    function automatic logic bank_ok(input logic [BANK_W-1:0] b);
        return ({1'b0, b} < NUM_BANKS_W);
    endfunction

    assign run = (state_q == ST_RUN);

    // INIT walks every entry of every bank once, then RUN holds until reset.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + CNT_W'(1);
                if (init_cnt_q == LAST_CNT) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Write port owner: the init sequencer during INIT, user writes in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt_q[AW-1:0];
            ram_wdata = RGB_W'(default_color(32'(init_cnt_q[IDX_W-1:0]), 12'(ERR_COLOR)));
        end else if (bus.wr_en && bank_ok(bus.wr_bank)) begin
            ram_we    = 1'b1;
            ram_waddr = {bus.wr_bank, bus.wr_addr};
            ram_wdata = bus.wr_data;
        end
    end

    // Lookup pipeline and frame-synchronous bank switch.
    always_comb begin
        s1_valid_d    = run & bus.pix_valid_in;
        s1_index_d    = bus.pix_index;
        s1_bank_d     = active_bank_q;
        out_valid_d   = s1_valid_q;
        out_opaque_d  = out_opaque_q;
        active_bank_d = active_bank_q;
        if (s1_valid_q) begin
            out_opaque_d = (s1_index_q != TRANS_I);
        end
        if (run && bus.frame_start && bank_ok(bus.bank_sel_req)) begin
            active_bank_d = bus.bank_sel_req;
        end
    end

    assign ram_re    = s1_valid_q;
    assign ram_raddr = {s1_bank_q, s1_index_q};

    // Control registers: FSM, init counter and displayed bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            active_bank_q <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            active_bank_q <= active_bank_d;
        end
    end

    // Pipeline registers; reset flushes any lookup in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_index_q   <= '0;
            s1_bank_q    <= '0;
            out_valid_q  <= 1'b0;
            out_opaque_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_index_q   <= s1_index_d;
            s1_bank_q    <= s1_bank_d;
            out_valid_q  <= out_valid_d;
            out_opaque_q <= out_opaque_d;
        end
    end

    palette_lut_bank_ram #(
        .AW    (AW),
        .RGB_W (RGB_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // A transparent pixel forces black, which also keeps the output at zero
    // after reset before the first lookup has loaded the read register.
    assign bus.pix_valid_out = out_valid_q;
    assign bus.pix_opaque    = out_opaque_q;
    assign bus.pix_rgb       = out_opaque_q ? ram_rdata : '0;
    assign bus.active_bank   = active_bank_q;
    assign bus.wr_ready      = run;
    assign bus.init_done     = run;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: a default two-bank instance carries the
// scoreboarded pixel stream, a three-bank instance covers out-of-range bank ids.
module tb_palette_lut;

    localparam logic [11:0] DEF_TAB [9] = '{12'h000, 12'hD42, 12'h921, 12'hFF9,
                                            12'h210, 12'h778, 12'h6B4, 12'hDD0, 12'hFFF};
    localparam logic [11:0] ERR_COL = 12'hF0F;
    localparam int          INIT_A  = 32;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        opaque;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    palette_lut_if #(.IDX_W(4), .RGB_W(12), .BANK_W(1)) a_if ();
    palette_lut_if #(.IDX_W(4), .RGB_W(12), .BANK_W(2)) b_if ();

    palette_lut #(.NUM_BANKS(2)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
    palette_lut #(.NUM_BANKS(3)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

    exp_t        sbq [$];
    logic [11:0] model_mem [2][16];
    logic        model_bank;
    logic        model_run;
    int          model_cnt;
    logic [11:0] last_rgb;
    logic        last_opq;
    int          step;
    int          compared;
    int          mismatched;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idleB();
        b_if.pix_valid_in = 1'b0;
        b_if.pix_index    = 4'd0;
        b_if.frame_start  = 1'b0;
        b_if.bank_sel_req = 2'd0;
        b_if.wr_en        = 1'b0;
        b_if.wr_bank      = 2'd0;
        b_if.wr_addr      = 4'd0;
        b_if.wr_data      = 12'h000;
    endtask

    // One clock of stimulus on instance A, with the scoreboard and model updated.
    task automatic applyStimulus(input logic pv, input logic [3:0] idx, input logic fs,
                                 input logic bsel, input logic we, input logic wb,
                                 input logic [3:0] wa, input logic [11:0] wd);
        exp_t e;
        logic cur_bank;
        logic exp_v;
        a_if.pix_valid_in = pv;
        a_if.pix_index    = idx;
        a_if.frame_start  = fs;
        a_if.bank_sel_req = bsel;
        a_if.wr_en        = we;
        a_if.wr_bank      = wb;
        a_if.wr_addr      = wa;
        a_if.wr_data      = wd;
        cur_bank = model_bank;
        if (model_run) begin
            if (we) model_mem[wb][wa] = wd;
            if (pv) begin
                e.due    = step + 2;
                e.opaque = (idx != 4'd0);
                e.rgb    = e.opaque ? model_mem[cur_bank][idx] : 12'h000;
                sbq.push_back(e);
            end
            if (fs) model_bank = bsel;
        end
        @(posedge clk);
        #1;
        step++;
        if (!model_run) begin
            model_cnt++;
            if (model_cnt == INIT_A) model_run = 1'b1;
        end
        exp_v = (sbq.size() != 0) && (sbq[0].due == step);
        checkOutput("valid_out", 32'(a_if.pix_valid_out), 32'(exp_v));
        if (exp_v) begin
            e = sbq.pop_front();
            checkOutput("pix_rgb", 32'(a_if.pix_rgb), 32'(e.rgb));
            checkOutput("pix_opaque", 32'(a_if.pix_opaque), 32'(e.opaque));
            last_rgb = e.rgb;
            last_opq = e.opaque;
        end else begin
            checkOutput("hold_rgb", 32'(a_if.pix_rgb), 32'(last_rgb));
            checkOutput("hold_opaque", 32'(a_if.pix_opaque), 32'(last_opq));
        end
        checkOutput("active_bank", 32'(a_if.active_bank), 32'(model_bank));
        checkOutput("init_done", 32'(a_if.init_done), 32'(model_run));
        checkOutput("wr_ready", 32'(a_if.wr_ready), 32'(model_run));
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
    endtask

    // One reset clock with input traffic present; everything must clear.
    task automatic applyReset();
        rst = 1'b1;
        a_if.pix_valid_in = 1'b1;
        a_if.wr_en        = 1'b0;
        a_if.frame_start  = 1'b0;
        idleB();
        @(posedge clk);
        #1;
        step++;
        sbq.delete();
        model_run  = 1'b0;
        model_cnt  = 0;
        model_bank = 1'b0;
        last_rgb   = 12'h000;
        last_opq   = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < 16; e++) begin
                model_mem[b][e] = (e < 9) ? DEF_TAB[e] : ERR_COL;
            end
        end
        checkOutput("rst_valid_out", 32'(a_if.pix_valid_out), 32'd0);
        checkOutput("rst_pix_rgb", 32'(a_if.pix_rgb), 32'd0);
        checkOutput("rst_pix_opaque", 32'(a_if.pix_opaque), 32'd0);
        checkOutput("rst_active_bank", 32'(a_if.active_bank), 32'd0);
        checkOutput("rst_init_done", 32'(a_if.init_done), 32'd0);
        checkOutput("rst_wr_ready", 32'(a_if.wr_ready), 32'd0);
        rst = 1'b0;
    endtask

    // Steps through INIT while offering ignored traffic; returns cycles counted.
    task automatic waitInit(output int n);
        n = 0;
        while (!a_if.init_done && n < 60) begin
            applyStimulus(1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 12'hABC);
            n++;
        end
    endtask

    initial begin
        int n;
        compared   = 0;
        mismatched = 0;
        step       = 0;
        rst        = 1'b0;
        a_if.pix_valid_in = 1'b0;
        a_if.pix_index    = 4'd0;
        a_if.frame_start  = 1'b0;
        a_if.bank_sel_req = 1'b0;
        a_if.wr_en        = 1'b0;
        a_if.wr_bank      = 1'b0;
        a_if.wr_addr      = 4'd0;
        a_if.wr_data      = 12'h000;
        idleB();
        $display("[TB] palette_lut bench starting");

        // Reset, then INIT must take exactly 32 cycles with no output activity.
        applyReset();
        waitInit(n);
        checkOutput("init_cycles", 32'(n), 32'd32);

        // Stream every index through bank 0.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        end
        applyIdle();
        applyIdle();

        // Write bank 1, switch on frame_start; the pixel in that cycle uses bank 0.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 12'h0F0);
        applyIdle();
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 12'h000);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyIdle();
        applyIdle();

        // Back to bank 0; a write racing the stage-2 read returns the old colour.
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 12'hABC);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyIdle();
        applyIdle();

        // Transparent index reads as black even after its entry is rewritten.
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h123);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyIdle();
        applyIdle();
        applyIdle();

        // Three-bank instance: out-of-range bank select and write are dropped.
        n = 0;
        while (!b_if.init_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b_init_done", 32'(b_if.init_done), 32'd1);
        b_if.frame_start  = 1'b1;
        b_if.bank_sel_req = 2'd2;
        @(posedge clk);
        #1;
        checkOutput("b_bank_sel_2", 32'(b_if.active_bank), 32'd2);
        b_if.bank_sel_req = 2'd3;
        b_if.wr_en        = 1'b1;
        b_if.wr_bank      = 2'd3;
        b_if.wr_addr      = 4'd3;
        b_if.wr_data      = 12'h0F0;
        @(posedge clk);
        #1;
        checkOutput("b_bank_sel_oob", 32'(b_if.active_bank), 32'd2);
        b_if.frame_start  = 1'b0;
        b_if.wr_bank      = 2'd2;
        b_if.wr_addr      = 4'd4;
        b_if.wr_data      = 12'h5A5;
        b_if.pix_valid_in = 1'b1;
        b_if.pix_index    = 4'd3;
        @(posedge clk);
        #1;
        b_if.wr_en     = 1'b0;
        b_if.pix_index = 4'd4;
        @(posedge clk);
        #1;
        checkOutput("b_valid_1", 32'(b_if.pix_valid_out), 32'd1);
        checkOutput("b_rgb_bank2_idx3", 32'(b_if.pix_rgb), 32'h0FF9);
        b_if.pix_valid_in = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("b_valid_2", 32'(b_if.pix_valid_out), 32'd1);
        checkOutput("b_rgb_bank2_idx4", 32'(b_if.pix_rgb), 32'h05A5);
        idleB();

        // Reset mid-stream after user writes: flush, re-init, defaults are back.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 12'h111);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyReset();
        waitInit(n);
        checkOutput("reinit_cycles", 32'(n), 32'd32);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h000);
        applyIdle();
        applyIdle();
        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
